// File: rtl/instr_cache_pkg.sv
// Shared types and helpers for the direct-mapped instruction cache.
// Optional statistics counters are enabled with the INSTR_CACHE_STATS_EN macro.
package instr_cache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    localparam logic [31:0] DEF_BASE_ADDR = 32'hBFC00000;
    localparam int          DEF_ROM_BYTES = 4096;

    // Assemble a 32-bit word from four bytes, lowest address in the low byte.
    function automatic logic [31:0] le_word(input logic [7:0] b0,
                                            input logic [7:0] b1,
                                            input logic [7:0] b2,
                                            input logic [7:0] b3);
        return {b3, b2, b1, b0};
    endfunction

endpackage

// File: rtl/instr_cache_rom.sv
// Byte-addressed instruction ROM backing the cache. The byte array is loaded
// externally (HEX_FILE is kept for interface compatibility). The read is
// combinational and little-endian.
module instr_rom
    import instr_cache_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = ADDRESS_WIDTH'(DEF_BASE_ADDR),
    parameter int                       ROM_BYTES     = DEF_ROM_BYTES,
    parameter string                    HEX_FILE      = "program.hex"
) (
    input  logic [ADDRESS_WIDTH-1:0] addr_i,
    output logic [31:0]              data_o
);

    localparam int OFF_W = $clog2(ROM_BYTES);

    logic [7:0]               mem [ROM_BYTES];
    logic [ADDRESS_WIDTH-1:0] diff;
    logic [OFF_W-1:0]         off;

    // Little-endian word read; addresses outside the image read as zero.
    always_comb begin
        diff   = addr_i - BASE_ADDR;
        off    = diff[OFF_W-1:0];
        data_o = '0;
        if (diff <= ADDRESS_WIDTH'(ROM_BYTES - 4)) begin
            data_o = le_word(mem[off], mem[off + OFF_W'(1)],
                             mem[off + OFF_W'(2)], mem[off + OFF_W'(3)]);
        end
    end

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped instruction cache: combinational hit path, fixed-latency line
// fill from instr_rom on a miss. Define INSTR_CACHE_STATS_EN to add the
// saturating hit_count / miss_count outputs.
module instr_cache
    import instr_cache_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH     = 32,
    parameter int                       INSTRUCTION_WIDTH = 32,
    parameter int                       SETS              = 16,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR         = ADDRESS_WIDTH'(DEF_BASE_ADDR),
    parameter int                       ROM_BYTES         = DEF_ROM_BYTES,
    parameter int                       MISS_LATENCY      = 4,
    parameter string                    HEX_FILE          = "program.hex"
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    input  logic [ADDRESS_WIDTH-1:0]     req_addr,
    input  logic                         flush,
    output logic                         resp_valid,
    output logic [INSTRUCTION_WIDTH-1:0] resp_instr,
    output logic                         stall,
    output logic                         fault
`ifdef INSTR_CACHE_STATS_EN
    ,
    output logic [31:0]                  hit_count,
    output logic [31:0]                  miss_count
`endif
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDRESS_WIDTH - IDX_W - 2;
    localparam int CNT_W = (MISS_LATENCY > 1) ? $clog2(MISS_LATENCY) : 1;
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_HI = BASE_ADDR + ADDRESS_WIDTH'(ROM_BYTES - 4);

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [ADDRESS_WIDTH-1:0]     addr_q, addr_d;
    logic [SETS-1:0]              valid_q;
    logic [TAG_W-1:0]             tag_q  [SETS];
    logic [INSTRUCTION_WIDTH-1:0] data_q [SETS];

    logic [IDX_W-1:0]             req_idx, fill_idx;
    logic [TAG_W-1:0]             req_tag, fill_tag;
    logic                         hit_line, fill_we;
    logic [INSTRUCTION_WIDTH-1:0] rom_word;

    assign req_idx  = req_addr[IDX_W+1:2];
    assign req_tag  = req_addr[ADDRESS_WIDTH-1:IDX_W+2];
    assign fill_idx = addr_q[IDX_W+1:2];
    assign fill_tag = addr_q[ADDRESS_WIDTH-1:IDX_W+2];
    assign hit_line = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign fault    = req_valid && ((req_addr[1:0] != 2'b00) ||
                                    (req_addr < BASE_ADDR) || (req_addr > ADDR_HI));

    instr_rom #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .BASE_ADDR     (BASE_ADDR),
        .ROM_BYTES     (ROM_BYTES),
        .HEX_FILE      (HEX_FILE)
    ) u_rom (
        .addr_i (addr_q),
        .data_o (rom_word)
    );

    // Lookup, miss detection and fill sequencing; a flushed request is held off with stall.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        fill_we    = 1'b0;
        resp_valid = 1'b0;
        resp_instr = '0;
        stall      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid && !fault) begin
                    if (flush) begin
                        stall = 1'b1;
                    end else if (hit_line) begin
                        resp_valid = 1'b1;
                        resp_instr = data_q[req_idx];
                    end else begin
                        stall   = 1'b1;
                        addr_d  = req_addr;
                        cnt_d   = CNT_W'(MISS_LATENCY - 1);
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                stall = 1'b1;
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    fill_we = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state: FSM, latency counter and valid bits (flush wins over a fill write).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (flush) begin
                valid_q <= '0;
            end else if (fill_we) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    // Datapath storage: latched miss address plus tag/instruction arrays.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        if (fill_we) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= rom_word;
        end
    end

`ifdef INSTR_CACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    // Saturating statistics: hits per responding cycle, misses per IDLE->FILL entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (resp_valid && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + 32'd1;
            if ((state_q == IDLE) && (state_d == FILL) && (miss_cnt_q != '1))
                miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_instr_cache.sv
// Self-checking bench for instr_cache. Expected instructions come from the
// bench's own ROM image and are queued when a request is issued, then popped
// when the cache responds.
module tb_instr_cache;

    localparam logic [31:0] B    = 32'hBFC00000;
    localparam int          ML   = 4;
    localparam int          RB   = 4096;
    localparam int          MISS = ML + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = B;
    logic        flush = 1'b0;
    logic        resp_valid;
    logic [31:0] resp_instr;
    logic        stall;
    logic        fault;
`ifdef INSTR_CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    instr_cache #(
        .ADDRESS_WIDTH     (32),
        .INSTRUCTION_WIDTH (32),
        .SETS              (16),
        .BASE_ADDR         (B),
        .ROM_BYTES         (RB),
        .MISS_LATENCY      (ML),
        .HEX_FILE          ("")
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_instr (resp_instr),
        .stall      (stall),
        .fault      (fault)
`ifdef INSTR_CACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  img [RB];
    logic [31:0] exp_q [$];

    function automatic logic [31:0] img_word(input logic [31:0] a);
        int o;
        o = int'(a - B);
        return {img[o+3], img[o+2], img[o+1], img[o]};
    endfunction

    // Issue one request and wait for its response, checking data and stall length.
    task automatic fetch(input logic [31:0] a, input int exp_stall, input string name);
        int          n;
        logic        got;
        logic [31:0] e;
        exp_q.push_back(img_word(a));
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_addr  = a;
        n   = 0;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (resp_valid) got = 1'b1;
            else if (stall) n++;
        end
        e = exp_q.pop_front();
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL %s: no resp_valid within bound (stall cycles %0d, wanted %0d)", name, n, exp_stall);
        end else begin
            if (resp_instr !== e) begin
                miscompares++;
                $display("FAIL %s instr: got %h want %h", name, resp_instr, e);
            end
            vectors++;
            if (n != exp_stall) begin
                miscompares++;
                $display("FAIL %s stall_cycles: got %0d want %0d", name, n, exp_stall);
            end
            vectors++;
            if (stall !== 1'b0) begin
                miscompares++;
                $display("FAIL %s stall_at_resp: got %b want 0", name, stall);
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({resp_valid, resp_instr, stall, fault} !== 35'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rv=%b instr=%h stall=%b fault=%b want all 0",
                     resp_valid, resp_instr, stall, fault);
        end
        req_valid = 1'b1;
        req_addr  = B;
        #1;
        vectors++;
        if (stall !== 1'b1 || resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_cold_miss: got stall=%b rv=%b want stall=1 rv=0", stall, resp_valid);
        end
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_miss_hit();
        fetch(B, MISS, "cold_miss");
        fetch(B, 0, "rerequest_hit");
    endtask

    task automatic test_conflict();
        fetch(B + 32'h40, MISS, "conflict_evict_first");
        fetch(B, MISS, "conflict_evict_second");
    endtask

    task automatic test_flush();
        logic [31:0] a;
        a = B + 32'h10;
        fetch(B, 0, "flush_pre_hit");
        // flush on a would-be hit suppresses the response
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = B; flush = 1'b1;
        @(negedge clk);
        vectors++;
        if (resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_hit_suppressed: got rv=%b want 0", resp_valid);
        end
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        // flush on the second FILL cycle aborts the fill
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = a;
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        vectors++;
        if (stall !== 1'b1 || resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_in_fill: got stall=%b rv=%b want stall=1 rv=0", stall, resp_valid);
        end
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        fetch(a, MISS, "flush_fill_aborted");
        fetch(B, MISS, "flush_cleared_line");
    endtask

    task automatic test_addr_change();
        logic [31:0] a1, a2, e;
        int          n;
        logic        got;
        a1 = B + 32'h20;
        a2 = B + 32'h24;
        exp_q.push_back(img_word(a2));
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = a1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req_addr = a2;
        n   = 2;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (resp_valid) got = 1'b1;
            else if (stall) n++;
        end
        e = exp_q.pop_front();
        vectors++;
        if (!got || resp_instr !== e || n != 2 * MISS) begin
            miscompares++;
            $display("FAIL addr_change_new: got rv=%b instr=%h stall_cycles=%0d want rv=1 instr=%h stall_cycles=%0d",
                     got, resp_instr, n, e, 2 * MISS);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        fetch(a1, 0, "addr_change_old_filled");
    endtask

    task automatic test_fault();
        logic [31:0] bad [3];
        bad[0] = B + 32'h2;
        bad[1] = B + 32'h1000;
        bad[2] = B - 32'h4;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            req_valid = 1'b1; req_addr = bad[i];
            @(negedge clk);
            vectors++;
            if (fault !== 1'b1 || stall !== 1'b0 || resp_valid !== 1'b0 || resp_instr !== 32'd0) begin
                miscompares++;
                $display("FAIL fault_%0d addr %h: got fault=%b stall=%b rv=%b instr=%h want 1 0 0 0",
                         i, bad[i], fault, stall, resp_valid, resp_instr);
            end
        end
        req_valid = 1'b0;
        #1;
        vectors++;
        if (fault !== 1'b0) begin
            miscompares++;
            $display("FAIL fault_without_valid: got %b want 0", fault);
        end
        fetch(B, 0, "fault_no_state_change");
        fetch(B + 32'hFFC, MISS, "top_word_in_range");
    endtask

    task automatic test_back_to_back();
        logic [31:0] seq [5];
        logic [31:0] e;
        seq[0] = B; seq[1] = B + 32'h10; seq[2] = B + 32'h20;
        seq[3] = B + 32'h24; seq[4] = B + 32'hFFC;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(img_word(seq[i]));
            @(posedge clk); #1;
            req_valid = 1'b1; req_addr = seq[i];
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (resp_valid !== 1'b1 || stall !== 1'b0 || resp_instr !== e) begin
                miscompares++;
                $display("FAIL b2b_%0d: got rv=%b stall=%b instr=%h want rv=1 stall=0 instr=%h",
                         i, resp_valid, stall, resp_instr, e);
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] a;
        a = B + 32'h30;
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = a;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (stall !== 1'b1 || resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_fill: got stall=%b rv=%b want stall=1 rv=0", stall, resp_valid);
        end
`ifdef INSTR_CACHE_STATS_EN
        vectors++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            miscompares++;
            $display("FAIL rst_stats: got hits=%0d misses=%0d want 0 0", hit_count, miss_count);
        end
`endif
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        fetch(a, MISS, "rst_fill_aborted");
    endtask

`ifdef INSTR_CACHE_STATS_EN
    task automatic test_stats();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            miscompares++;
            $display("FAIL stats_reset: got hits=%0d misses=%0d want 0 0", hit_count, miss_count);
        end
        fetch(B, MISS, "stats_a");
        fetch(B, 0, "stats_b");
        fetch(B + 32'h40, MISS, "stats_c");
        fetch(B, MISS, "stats_d");
        @(negedge clk);
        vectors++;
        if (hit_count !== 32'd4 || miss_count !== 32'd3) begin
            miscompares++;
            $display("FAIL stats_counts: got hits=%0d misses=%0d want 4 3", hit_count, miss_count);
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        vectors++;
        if (hit_count !== 32'd4 || miss_count !== 32'd3) begin
            miscompares++;
            $display("FAIL stats_flush: got hits=%0d misses=%0d want 4 3", hit_count, miss_count);
        end
        test_reset_mid_fill();
    endtask
`endif

    initial begin
        for (int i = 0; i < RB; i++) img[i] = 8'($urandom);
        img[0] = 8'h13; img[1] = 8'h05; img[2] = 8'hA0; img[3] = 8'h00;
        for (int i = 0; i < RB; i++) dut.u_rom.mem[i[11:0]] = img[i];

        test_reset();
        test_miss_hit();
        vectors++;
        if (img_word(B) !== 32'h00A00513) begin
            miscompares++;
            $display("FAIL image_word0: got %h want 00a00513", img_word(B));
        end
        test_conflict();
        test_flush();
        test_addr_change();
        test_fault();
        test_back_to_back();
        test_reset_mid_fill();
`ifdef INSTR_CACHE_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
